// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and helpers for the pipeline hazard/exception controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  // TUSE/TNEW encodings: cycles until an operand is needed or a result exists.
  localparam logic [1:0] T_0    = 2'd0;
  localparam logic [1:0] T_1    = 2'd1;
  localparam logic [1:0] T_2    = 2'd2;
  localparam logic [1:0] T_NONE = 2'd3;  // TUSE only: operand not read

  localparam int CNT_W = 4;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // A source register is a hazard if an in-flight producer writes it and
  // the result will not be ready by the time ID needs it. r0 never hazards.
  function automatic logic src_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] ex_wa,
    input logic [1:0] ex_tnew,
    input logic [4:0] mem_wa,
    input logic [1:0] mem_tnew
  );
    logic ex_hit;
    logic mem_hit;
    ex_hit  = (src == ex_wa)  && (tuse < ex_tnew);
    mem_hit = (src == mem_wa) && (tuse < mem_tnew);
    return (src != 5'd0) && (ex_hit || mem_hit);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of pipeline status inputs and control outputs for pipe_ctrl.
// Latency: n/a (wiring only).
// Backpressure: stall is the only hold-off; it is produced by the slave.
interface pipe_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic [1:0] id_tuse_rs;
  logic [1:0] id_tuse_rt;
  logic [4:0] ex_wa;
  logic [4:0] mem_wa;
  logic [1:0] ex_tnew;
  logic [1:0] mem_tnew;
  logic       id_is_md;
  logic       ex_md_start;
  logic       ex_md_div;
  logic       id_eret;
  logic       ex_mtc0_epc;
  logic       mem_mtc0_epc;
  logic       int_req;
  logic       stall;
  logic       flush_id_ex;
  logic       req;
  logic       md_busy;

  // Pipeline side: drives status, consumes control.
  modport master (
    output id_rs, id_rt, id_tuse_rs, id_tuse_rt, ex_wa, mem_wa, ex_tnew,
           mem_tnew, id_is_md, ex_md_start, ex_md_div, id_eret, ex_mtc0_epc,
           mem_mtc0_epc, int_req,
    input  stall, flush_id_ex, req, md_busy
  );

  // Controller side.
  modport slave (
    input  id_rs, id_rt, id_tuse_rs, id_tuse_rt, ex_wa, mem_wa, ex_tnew,
           mem_tnew, id_is_md, ex_md_start, ex_md_div, id_eret, ex_mtc0_epc,
           mem_mtc0_epc, int_req,
    output stall, flush_id_ex, req, md_busy
  );
endinterface

// File: rtl/pipe_ctrl_md_sched.sv
// Multiply/divide occupancy tracker: counts the busy cycles of a started op.
// Latency: busy rises one clock after an accepted start, lasts MULT_CYC/DIV_CYC.
// Backpressure: starts while busy or while killed are dropped, never queued.
module md_sched
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div,
  input  logic kill,
  output logic busy
);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // State and counter registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a killed start belongs to a squashed instruction; once busy,
  // the op is committed so kill is not looked at.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MD_IDLE: begin
        if (start && !kill) begin
          cnt_d   = div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
          state_d = MD_BUSY;
        end
      end
      MD_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = MD_IDLE;
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q == MD_BUSY);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard and exception controller: stall/flush/redirect decisions.
// Latency: stall, flush_id_ex and req are combinational; md_busy is registered.
// Backpressure: stall holds IF/ID and PC; an exception redirect overrides it.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic          clk,
  input  logic          reset,
  pipe_ctrl_if.slave    pif
);

  logic rs_hz;
  logic rt_hz;
  logic md_hz;
  logic eret_hz;
  logic req_int;
  logic md_busy_int;

  md_sched #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_sched (
    .clk   (clk),
    .reset (reset),
    .start (pif.ex_md_start),
    .div   (pif.ex_md_div),
    .kill  (req_int),
    .busy  (md_busy_int)
  );

  // Hazard detection: operand readiness, MD unit occupancy, and eret reading
  // an EPC that an older mtc0 has not yet written.
  always_comb begin
    rs_hz   = src_hazard(pif.id_rs, pif.id_tuse_rs, pif.ex_wa, pif.ex_tnew,
                         pif.mem_wa, pif.mem_tnew);
    rt_hz   = src_hazard(pif.id_rt, pif.id_tuse_rt, pif.ex_wa, pif.ex_tnew,
                         pif.mem_wa, pif.mem_tnew);
    md_hz   = pif.id_is_md && (md_busy_int || pif.ex_md_start);
    eret_hz = pif.id_eret && (pif.ex_mtc0_epc || pif.mem_mtc0_epc);
  end

  // Output control: a redirect flushes everything anyway, so it wins over a
  // stall; reset silences all control outputs.
  always_comb begin
    req_int         = pif.int_req && !reset;
    pif.req         = req_int;
    pif.stall       = (rs_hz || rt_hz || md_hz || eret_hz) && !req_int && !reset;
    pif.flush_id_ex = pif.stall;
    pif.md_busy     = md_busy_int;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic.
// Latency: outputs compared on the falling edge every cycle after reset.
// Backpressure: n/a.
module tb_pipe_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;
  int   md_left = 0;  // model: remaining busy cycles of the MD unit

  pipe_ctrl_if pif ();

  pipe_ctrl #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .pif   (pif)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: MD unit is busy for a fixed number of cycles after an
  // accepted start; starts while busy or during a redirect are dropped.
  always @(posedge clk) begin
    if (reset) md_left <= 0;
    else if (md_left > 0) md_left <= md_left - 1;
    else if (pif.ex_md_start && !pif.int_req)
      md_left <= pif.ex_md_div ? DIV_N : MULT_N;
  end

  function automatic bit hz(input int r, input int tu, input int ew,
                            input int et, input int mw, input int mt);
    if (r == 0) return 0;
    return (r == ew && tu < et) || (r == mw && tu < mt);
  endfunction

  // Continuous comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      bit busy_e, req_e, stall_e;
      busy_e = (md_left > 0);
      req_e  = pif.int_req && !reset;
      stall_e = (hz(pif.id_rs, pif.id_tuse_rs, pif.ex_wa, pif.ex_tnew, pif.mem_wa, pif.mem_tnew)
              || hz(pif.id_rt, pif.id_tuse_rt, pif.ex_wa, pif.ex_tnew, pif.mem_wa, pif.mem_tnew)
              || (pif.id_is_md && (busy_e || pif.ex_md_start))
              || (pif.id_eret && (pif.ex_mtc0_epc || pif.mem_mtc0_epc)))
              && !req_e && !reset;
      check("model_md_busy", pif.md_busy, busy_e);
      check("model_req",     pif.req,     req_e);
      check("model_stall",   pif.stall,   stall_e);
      check("model_flush",   pif.flush_id_ex, stall_e);
    end
  end

  task automatic clear_inputs();
    pif.id_rs = 0; pif.id_rt = 0; pif.id_tuse_rs = 3; pif.id_tuse_rt = 3;
    pif.ex_wa = 0; pif.mem_wa = 0; pif.ex_tnew = 0; pif.mem_tnew = 0;
    pif.id_is_md = 0; pif.ex_md_start = 0; pif.ex_md_div = 0;
    pif.id_eret = 0; pif.ex_mtc0_epc = 0; pif.mem_mtc0_epc = 0;
    pif.int_req = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int busy_cnt, stall_cnt;
    clear_inputs();
    reset = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    @(negedge clk);
    check("reset_md_busy", pif.md_busy, 0);
    check("reset_stall", pif.stall, 0);
    reset = 1'b0;
    step();

    // Load-use style data hazard, then r0 source which never hazards.
    pif.id_rs = 8; pif.id_tuse_rs = 0; pif.ex_wa = 8; pif.ex_tnew = 1;
    @(negedge clk);
    check("rs_hz_stall", pif.stall, 1);
    check("rs_hz_flush", pif.flush_id_ex, 1);
    step();
    pif.id_rs = 0;
    @(negedge clk);
    check("r0_no_stall", pif.stall, 0);
    step();
    clear_inputs();

    // mult with mflo waiting in ID.
    pif.ex_md_start = 1; pif.ex_md_div = 0; pif.id_is_md = 1;
    busy_cnt = 0; stall_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      busy_cnt  += int'(pif.md_busy);
      stall_cnt += int'(pif.stall);
      step();
      pif.ex_md_start = 0;
    end
    check("mult_busy_cycles", busy_cnt, 5);
    check("mflo_stall_cycles", stall_cnt, 6);
    clear_inputs();

    // div start squashed by a simultaneous exception.
    pif.ex_md_start = 1; pif.ex_md_div = 1; pif.int_req = 1; pif.id_is_md = 1;
    @(negedge clk);
    check("div_kill_req", pif.req, 1);
    check("div_kill_stall", pif.stall, 0);
    step();
    clear_inputs();
    @(negedge clk);
    check("div_kill_busy", pif.md_busy, 0);
    step();

    // Exception during a data hazard.
    pif.id_rt = 5; pif.id_tuse_rt = 1; pif.mem_wa = 5; pif.mem_tnew = 2;
    @(negedge clk);
    check("hz_pre_int_stall", pif.stall, 1);
    pif.int_req = 1;
    #1;
    check("int_over_hz_req", pif.req, 1);
    check("int_over_hz_stall", pif.stall, 0);
    step();
    clear_inputs();

    // eret behind mtc0 EPC in MEM: one stall cycle.
    pif.id_eret = 1; pif.mem_mtc0_epc = 1;
    @(negedge clk);
    check("eret_stall", pif.stall, 1);
    step();
    pif.mem_mtc0_epc = 0;
    @(negedge clk);
    check("eret_release", pif.stall, 0);
    step();
    clear_inputs();

    // Reset while busy with cnt=4.
    pif.ex_md_start = 1; pif.ex_md_div = 0;
    step();
    pif.ex_md_start = 0;
    step();
    reset = 1; pif.int_req = 1; pif.id_is_md = 1;
    pif.id_rs = 3; pif.id_tuse_rs = 0; pif.ex_wa = 3; pif.ex_tnew = 2;
    @(negedge clk);
    check("rst_hold_busy_still", pif.md_busy, 1);
    check("rst_hold_stall", pif.stall, 0);
    check("rst_hold_flush", pif.flush_id_ex, 0);
    check("rst_hold_req", pif.req, 0);
    step();
    @(negedge clk);
    check("rst_busy_cleared", pif.md_busy, 0);
    check("rst_req_zero", pif.req, 0);
    reset = 0;
    clear_inputs();
    step();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      pif.id_rs        = 5'($urandom_range(0, 3));
      pif.id_rt        = 5'($urandom_range(0, 3));
      pif.id_tuse_rs   = 2'($urandom);
      pif.id_tuse_rt   = 2'($urandom);
      pif.ex_wa        = 5'($urandom_range(0, 3));
      pif.mem_wa       = 5'($urandom_range(0, 3));
      pif.ex_tnew      = 2'($urandom);
      pif.mem_tnew     = 2'($urandom);
      pif.id_is_md     = ($urandom_range(0, 3) == 0);
      pif.ex_md_start  = ($urandom_range(0, 7) == 0);
      pif.ex_md_div    = 1'($urandom);
      pif.id_eret      = ($urandom_range(0, 7) == 0);
      pif.ex_mtc0_epc  = ($urandom_range(0, 3) == 0);
      pif.mem_mtc0_epc = ($urandom_range(0, 3) == 0);
      pif.int_req      = ($urandom_range(0, 15) == 0);
      reset            = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
